pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the instruction memory. Each cycle it
//   increments the PC or loads a new one (jump, call, return). A two-state
//   RUN/HALTED machine stops the core on a breakpoint address or an external
//   request, and releases it again on resume.
//
//   Optional feature macro: PC_STACK_EN
//     defined   : hardware return stack; call pushes pc+1 and ret pops.
//                 Overflow and underflow raise sticky error flags and halt.
//     undefined : no stack storage; call acts as jump, ret is ignored,
//                 and depth/err_ovf/err_unf are tied to 0.
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     en        in   advance enable (RUN only)
//     jump      in   load target into pc
//     call      in   push pc+1 and load target
//     ret       in   pop the return address into pc
//     target    in   jump/call destination
//     halt_req  in   external halt request (level)
//     resume    in   leave HALTED (level)
//     pc        out  registered program counter
//     halted    out  1 while in HALTED
//     depth     out  return-stack occupancy
//     err_ovf   out  sticky: call on a full stack
//     err_unf   out  sticky: ret on an empty stack
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0,
    parameter int HALT_ADDR   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             jump,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                target,
    input  logic                             halt_req,
    input  logic                             resume,
    output logic [ADDR_W-1:0]                pc,
    output logic                             halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             err_ovf,
    output logic                             err_unf
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_go_halt;
    logic              w_advance;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_advance = (r_state == S_RUN) && en;

`ifdef PC_STACK_EN
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic               w_push;
    logic               w_pop;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic [IDX_W-1:0]   w_top_idx;
    logic [IDX_W-1:0]   w_push_idx;

    assign w_top_idx  = IDX_W'(r_depth - DEPTH_W'(1));
    assign w_push_idx = IDX_W'(r_depth);

    // Next-PC selection with priority halt_req > ret > call > jump > increment.
    always_comb begin
        w_pc_next = r_pc;
        w_go_halt = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (halt_req) begin
            w_go_halt = 1'b1;
        end else if (ret) begin
            if (r_depth != DEPTH_W'(0)) begin
                w_pop     = 1'b1;
                w_pc_next = r_stack[w_top_idx];
                w_go_halt = (r_stack[w_top_idx] == ADDR_W'(HALT_ADDR));
            end else begin
                w_set_unf = 1'b1;
                w_go_halt = 1'b1;
            end
        end else if (call) begin
            if (r_depth < DEPTH_W'(STACK_DEPTH)) begin
                w_push    = 1'b1;
                w_pc_next = target;
                w_go_halt = (target == ADDR_W'(HALT_ADDR));
            end else begin
                w_set_ovf = 1'b1;
                w_go_halt = 1'b1;
            end
        end else if (jump) begin
            w_pc_next = target;
            w_go_halt = (target == ADDR_W'(HALT_ADDR));
        end else begin
            w_pc_next = w_pc_inc;
            w_go_halt = (w_pc_inc == ADDR_W'(HALT_ADDR));
        end
    end

    // Stack and error flags: depth moves only on an accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth   <= DEPTH_W'(0);
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (w_advance) begin
            if (w_push) begin
                r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_pop) begin
                r_depth <= r_depth - DEPTH_W'(1);
            end else begin
                r_depth <= r_depth;
            end
            r_err_ovf <= r_err_ovf | w_set_ovf;
            r_err_unf <= r_err_unf | w_set_unf;
        end else begin
            r_depth   <= r_depth;
            r_err_ovf <= r_err_ovf;
            r_err_unf <= r_err_unf;
        end
    end

    // Stack storage: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (!rst && w_advance && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign depth   = r_depth;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
`else
    logic w_unused_ret;

    assign w_unused_ret = &{1'b0, ret};

    // Next-PC selection with priority halt_req > call/jump > increment.
    always_comb begin
        w_pc_next = r_pc;
        w_go_halt = 1'b0;
        if (halt_req) begin
            w_go_halt = 1'b1;
        end else if (call || jump) begin
            w_pc_next = target;
            w_go_halt = (target == ADDR_W'(HALT_ADDR));
        end else begin
            w_pc_next = w_pc_inc;
            w_go_halt = (w_pc_inc == ADDR_W'(HALT_ADDR));
        end
    end

    assign depth   = '0;
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    // RUN/HALTED state machine and program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= ADDR_W'(RESET_ADDR);
        end else begin
            case (r_state)
                S_RUN: begin
                    if (en) begin
                        r_pc <= w_pc_next;
                        if (w_go_halt) begin
                            r_state <= S_HALTED;
                        end
                    end
                end
                S_HALTED: begin
                    // pc holds; resuming never re-checks the breakpoint.
                    if (resume) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign pc     = r_pc;
    assign halted = (r_state == S_HALTED);

endmodule
